sd_saver: RTL and testbench

- RAM-to-microSD write-back engine; the store direction of the Linux-image copy path.
- Reads 32-bit words from RAM, packs them little-endian into a one-sector byte buffer, then streams the bytes to an SD-bus sector writer (sd_writer) on request.
- Repeats for NSECT consecutive sectors starting at SECTOR0, then pulses DONE.
- Sits between the memory controller read port and sd_writer, beside the existing SD load path.

---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_saver_if.sv | 27 ++
 rtl/sd_sector_buf.sv | 29 ++
 rtl/sd_saver.sv | 185 ++++++++++++++++++
 tb/tb_sd_saver.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared SD-path definitions: FSM encoding, sector size and byte-lane packing.
// Used by both the loader and the saver (sd_saver, optional SD_SAVER_SUM_EN).
package sd_pkg;

  localparam int unsigned SD_SECTOR_SIZE = 512;

  typedef logic [2:0] sd_state_t;

  localparam sd_state_t IDLE   = 3'd0;
  localparam sd_state_t FETCH  = 3'd1;
  localparam sd_state_t SEND   = 3'd2;
  localparam sd_state_t STREAM = 3'd3;
  localparam sd_state_t FIN    = 3'd4;

  // Little-endian lane select: lane 0 is the lowest-addressed byte.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/sd_saver_if.sv
// RAM read port and sd_writer handshake bundle seen by sd_saver.
// master = the saver, slave = memory controller plus sd_writer.
interface sd_saver_if;
  import sd_pkg::*;

  logic [31:0] RADDR;
  logic        RE;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        wstart;
  logic [31:0] wsector;
  logic        wbusy;
  logic        wdone;
  logic        inreq;
  logic [7:0]  inbyte;

  modport master (
    output RADDR, RE, wstart, wsector, inbyte,
    input  RDATA, RVALID, wbusy, wdone, inreq
  );

  modport slave (
    input  RADDR, RE, wstart, wsector, inbyte,
    output RDATA, RVALID, wbusy, wdone, inreq
  );

endinterface

// File: rtl/sd_sector_buf.sv
// One-sector byte buffer: 32-bit little-endian word writes, asynchronous byte reads.
module sd_sector_buf
  import sd_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = SD_SECTOR_SIZE,
  localparam int unsigned AW = $clog2(SECTOR_BYTES),
  localparam int unsigned KW = AW - 2
) (
  input  logic          clk27mhz,
  input  logic          we,
  input  logic [KW-1:0] k,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] rptr,
  output logic [7:0]    rbyte
);

  logic [7:0] mem [SECTOR_BYTES];

  always_ff @(posedge clk27mhz) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        mem[{k, 2'(i)}] <= byte_lane(wdata, 2'(i));
      end
    end
  end

  assign rbyte = mem[rptr];

endmodule

// File: rtl/sd_saver.sv
// RAM-to-microSD write-back engine: fills a sector buffer from RAM, streams it to sd_writer.
// Optional macro SD_SAVER_SUM_EN adds a running 32-bit SUM of all accepted RAM words.
module sd_saver
  import sd_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = SD_SECTOR_SIZE,
  parameter logic [31:0] MEM_BASE     = 32'h0,
  parameter int unsigned NSECT_W      = 16
) (
  input  logic               clk27mhz,
  input  logic               resetn,
  input  logic               START,
  input  logic [31:0]        SECTOR0,
  input  logic [NSECT_W-1:0] NSECT,
  sd_saver_if.master         bus,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
`ifdef SD_SAVER_SUM_EN
  ,
  output logic [31:0]        SUM
`endif
);

  localparam int unsigned AW = $clog2(SECTOR_BYTES);
  localparam int unsigned KW = AW - 2;
  localparam int unsigned BW = AW + 1;
  localparam logic [KW-1:0] KLast = KW'(SECTOR_BYTES / 4 - 1);
  localparam logic [BW-1:0] BEnd  = BW'(SECTOR_BYTES);

  sd_state_t          state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [BW-1:0]      bptr_q, bptr_d, bptr_srv;
  logic [31:0]        raddr_q, raddr_d;
  logic               re_q, re_d;
  logic               wstart_q, wstart_d;
  logic [31:0]        wsector_q, wsector_d;
  logic [NSECT_W-1:0] remain_q, remain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rd_accept;
  logic [7:0]         buf_byte;

  // RVALID only counts while our request is actually outstanding.
  assign rd_accept = (state_q == FETCH) && re_q && bus.RVALID;

  sd_sector_buf #(
    .SECTOR_BYTES(SECTOR_BYTES)
  ) u_buf (
    .clk27mhz(clk27mhz),
    .we      (rd_accept),
    .k       (k_q),
    .wdata   (bus.RDATA),
    .rptr    (bptr_q[AW-1:0]),
    .rbyte   (buf_byte)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bptr_d    = bptr_q;
    raddr_d   = raddr_q;
    re_d      = re_q;
    wstart_d  = wstart_q;
    wsector_d = wsector_q;
    remain_d  = remain_q;
    busy_d    = busy_q;
    err_d     = err_q;
    done_d    = 1'b0;
    bptr_srv  = bptr_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          wsector_d = SECTOR0;
          remain_d  = NSECT;
          raddr_d   = MEM_BASE;
          k_d       = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          if (NSECT == '0) begin
            state_d = FIN;
          end else begin
            state_d = FETCH;
            re_d    = 1'b1;
          end
        end
      end
      FETCH: begin
        if (!re_q) begin
          re_d = 1'b1;
        end else if (bus.RVALID) begin
          re_d    = 1'b0;
          raddr_d = raddr_q + 32'd4;
          k_d     = k_q + KW'(1);
          if (k_q == KLast) begin
            bptr_d   = '0;
            wstart_d = 1'b1;
            state_d  = SEND;
          end
        end
      end
      SEND: begin
        if (bus.wbusy) begin
          wstart_d = 1'b0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        // A byte served in the wdone cycle still counts toward the sector.
        if (bus.inreq) begin
          if (bptr_q == BEnd) err_d = 1'b1;
          else bptr_srv = bptr_q + BW'(1);
        end
        bptr_d = bptr_srv;
        if (bus.wdone) begin
          if (bptr_srv != BEnd) err_d = 1'b1;
          remain_d  = remain_q - NSECT_W'(1);
          wsector_d = wsector_q + 32'd1;
          state_d   = (remain_q == NSECT_W'(1)) ? FIN : FETCH;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      state_q   <= IDLE;
      k_q       <= '0;
      bptr_q    <= '0;
      raddr_q   <= MEM_BASE;
      re_q      <= 1'b0;
      wstart_q  <= 1'b0;
      wsector_q <= '0;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      bptr_q    <= bptr_d;
      raddr_q   <= raddr_d;
      re_q      <= re_d;
      wstart_q  <= wstart_d;
      wsector_q <= wsector_d;
      remain_q  <= remain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef SD_SAVER_SUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && START) begin
      sum_q <= '0;
    end else if (rd_accept) begin
      sum_q <= sum_q + bus.RDATA;
    end
  end

  assign SUM = sum_q;
`endif

  assign bus.RADDR   = raddr_q;
  assign bus.RE      = re_q;
  assign bus.wstart  = wstart_q;
  assign bus.wsector = wsector_q;
  assign bus.inbyte  = (bptr_q == BEnd) ? 8'h00 : buf_byte;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_sd_saver.sv
// Self-checking bench for sd_saver: random RAM contents, stalls and writer pacing,
// checked against a byte-level model of what the SD card should receive.
module tb_sd_saver;

  logic        clk27mhz = 1'b0;
  logic        resetn   = 1'b0;
  logic        START    = 1'b0;
  logic [31:0] SECTOR0  = '0;
  logic [15:0] NSECT    = '0;
  logic        BUSY, DONE, ERR;
`ifdef SD_SAVER_SUM_EN
  logic [31:0] SUM;
`endif

  sd_saver_if bus();

  sd_saver #(
    .SECTOR_BYTES(512),
    .MEM_BASE    (32'h0),
    .NSECT_W     (16)
  ) dut (
    .clk27mhz(clk27mhz),
    .resetn  (resetn),
    .START   (START),
    .SECTOR0 (SECTOR0),
    .NSECT   (NSECT),
    .bus     (bus),
    .BUSY    (BUSY),
    .DONE    (DONE),
`ifdef SD_SAVER_SUM_EN
    .ERR     (ERR),
    .SUM     (SUM)
`else
    .ERR     (ERR)
`endif
  );

  always #5 clk27mhz = ~clk27mhz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  logic [31:0] ram [0:2047];
  int          stall     = 0;
  int          stall_cnt = 0;
  bit          spur_en   = 0;
  int          hs_cnt    = 0;
  int          done_cnt  = 0;
  bit          re_seen   = 0;
  bit          ws_seen   = 0;
  logic [31:0] first_raddr = '0;
  logic [31:0] last_raddr  = '0;
  int          wr_nreq = 512;
  bit          wr_same = 0;
  logic [31:0] got_sect [$];
  logic [7:0]  got_bytes [$];

  // RAM responder: RVALID after `stall` cycles of RE, plus optional stray acks while RE=0.
  initial begin : mem_model
    bus.RVALID = 1'b0;
    bus.RDATA  = '0;
    forever begin
      @(negedge clk27mhz);
      if (DONE) done_cnt++;
      if (bus.RE) re_seen = 1;
      if (bus.wstart) ws_seen = 1;
      if (!resetn) begin
        bus.RVALID = 1'b0;
        stall_cnt  = 0;
      end else if (bus.RVALID) begin
        bus.RVALID = 1'b0;
      end else if (bus.RE) begin
        if (stall_cnt < stall) begin
          stall_cnt++;
        end else begin
          bus.RVALID = 1'b1;
          bus.RDATA  = ram[bus.RADDR[12:2]];
          if (hs_cnt == 0) first_raddr = bus.RADDR;
          last_raddr = bus.RADDR;
          hs_cnt++;
          stall_cnt = 0;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        bus.RVALID = 1'b1;
        bus.RDATA  = $urandom;
      end
    end
  end

  // sd_writer stand-in: accepts wstart, pulls wr_nreq bytes with random gaps, then wdone.
  initial begin : writer_model
    bus.wbusy = 1'b0;
    bus.wdone = 1'b0;
    bus.inreq = 1'b0;
    forever begin
      @(negedge clk27mhz);
      if (resetn && bus.wstart) begin
        got_sect.push_back(bus.wsector);
        repeat ($urandom_range(0, 2)) @(negedge clk27mhz);
        bus.wbusy = 1'b1;
        @(negedge clk27mhz);
        check_eq("wstart_drop", 32'(bus.wstart), 32'd0);
        for (int i = 0; i < wr_nreq; i++) begin
          bus.inreq = 1'b1;
          got_bytes.push_back(bus.inbyte);
          if (wr_same && i == wr_nreq - 1) bus.wdone = 1'b1;
          @(negedge clk27mhz);
          bus.inreq = 1'b0;
          bus.wdone = 1'b0;
          if (i != wr_nreq - 1 && $urandom_range(0, 3) == 0) @(negedge clk27mhz);
        end
        if (!wr_same) begin
          bus.wdone = 1'b1;
          @(negedge clk27mhz);
          bus.wdone = 1'b0;
        end
        bus.wbusy = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] s0, input int ns);
    @(negedge clk27mhz);
    START   = 1'b1;
    SECTOR0 = s0;
    NSECT   = 16'(ns);
    @(negedge clk27mhz);
    START   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check_eq({nm, ".raddr"}, bus.RADDR, 32'h0);
    check_eq({nm, ".re"}, 32'(bus.RE), 32'd0);
    check_eq({nm, ".wstart"}, 32'(bus.wstart), 32'd0);
    check_eq({nm, ".wsector"}, bus.wsector, 32'd0);
    check_eq({nm, ".busy"}, 32'(BUSY), 32'd0);
    check_eq({nm, ".done"}, 32'(DONE), 32'd0);
    check_eq({nm, ".err"}, 32'(ERR), 32'd0);
  endtask

  // One full transfer, then compare everything the writer and RAM saw against the model.
  task automatic run(input logic [31:0] s0, input int ns, input int nreq, input bit same,
                     input int stl, input bit spur, input string nm);
    int t, d0, j, b;
    logic [31:0] exp;
    got_sect.delete();
    got_bytes.delete();
    hs_cnt  = 0;
    stall   = stl;
    spur_en = spur;
    wr_nreq = nreq;
    wr_same = same;
    d0      = done_cnt;
    pulse_start(s0, ns);
    check_eq({nm, ".err_clr"}, 32'(ERR), 32'd0);
    check_eq({nm, ".busy"}, 32'(BUSY), 32'd1);
    t = 0;
    while (!DONE && t < ns * 4000 + 50) begin
      @(negedge clk27mhz);
      t++;
    end
    check_eq({nm, ".done"}, 32'(DONE), 32'd1);
    @(negedge clk27mhz);
    check_eq({nm, ".done_pulse"}, 32'(DONE), 32'd0);
    check_eq({nm, ".idle"}, 32'(BUSY), 32'd0);
    repeat (2) @(negedge clk27mhz);
    spur_en = 0;
    check_eq({nm, ".done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check_eq({nm, ".err"}, ERR, 32'(nreq != 512));
    check_eq({nm, ".nsect"}, 32'(got_sect.size()), 32'(ns));
    foreach (got_sect[i]) check_eq({nm, ".wsector"}, got_sect[i], s0 + 32'(i));
    check_eq({nm, ".nbytes"}, 32'(got_bytes.size()), 32'(ns * nreq));
    foreach (got_bytes[i]) begin
      j = i / nreq;
      b = i % nreq;
      exp = (b < 512) ? ((ram[(j * 128 + b / 4) & 2047] >> (8 * (b % 4))) & 32'hff) : 32'h0;
      check_eq({nm, ".byte"}, 32'(got_bytes[i]), exp);
    end
    check_eq({nm, ".handshakes"}, 32'(hs_cnt), 32'(ns * 128));
    if (ns > 0) begin
      check_eq({nm, ".first_raddr"}, first_raddr, 32'h0);
      check_eq({nm, ".last_raddr"}, last_raddr, 32'((ns * 128 - 1) * 4));
    end
  endtask

  initial begin : main
    int t, d0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'hA500_0000 | i;
    repeat (3) @(negedge clk27mhz);
    check_reset_outputs("reset");
`ifdef SD_SAVER_SUM_EN
    check_eq("reset.sum", SUM, 32'h0);
`endif
    resetn = 1'b1;

    run(32'd5, 1, 512, 0, 3, 0, "t1");
    check_eq("t1.byte0", 32'(got_bytes[0]), 32'h00);
    check_eq("t1.byte1", 32'(got_bytes[1]), 32'h00);
    check_eq("t1.byte3", 32'(got_bytes[3]), 32'hA5);
    check_eq("t1.byte4", 32'(got_bytes[4]), 32'h01);

    for (int i = 0; i < 2048; i++) ram[i] = $urandom;
    run(32'd100, 3, 512, 0, int'($urandom_range(0, 2)), 1, "t2");
    check_eq("t2.last_raddr", last_raddr, 32'h5FC);

    // Zero sectors: straight to FIN, no RAM or writer activity.
    re_seen = 0;
    ws_seen = 0;
    d0 = done_cnt;
    pulse_start(32'd77, 0);
    check_eq("t3.done_c1", 32'(DONE), 32'd0);
    @(negedge clk27mhz);
    check_eq("t3.done_c2", 32'(DONE), 32'd1);
    repeat (2) @(negedge clk27mhz);
    check_eq("t3.done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t3.busy", 32'(BUSY), 32'd0);
    check_eq("t3.re_seen", 32'(re_seen), 32'd0);
    check_eq("t3.ws_seen", 32'(ws_seen), 32'd0);

    run(32'd7, 1, 500, 0, 0, 0, "t4_short");
    run(32'hFFFF_FFFF, 2, 512, 1, 1, 1, "t5_wrap");
    run(32'd9, 1, 513, 0, 0, 0, "t6_over");
    run(32'd12, 1, 512, 1, 0, 0, "t7_clr");

    // Reset in the middle of filling the buffer.
    hs_cnt = 0;
    stall  = 0;
    pulse_start(32'd300, 2);
    t = 0;
    while (hs_cnt < 40 && t < 1000) begin
      @(negedge clk27mhz);
      t++;
    end
    check_eq("t8.reached40", 32'(hs_cnt >= 40), 32'd1);
    resetn = 1'b0;
    @(negedge clk27mhz);
    check_reset_outputs("t8");
    @(negedge clk27mhz);
    resetn = 1'b1;
    run(32'd11, 1, 512, 0, 1, 0, "t8_restart");

`ifdef SD_SAVER_SUM_EN
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0101_0101;
    run(32'd1, 1, 512, 0, 0, 1, "sum");
    check_eq("sum.value", SUM, 32'h8080_8080);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
